// File: rtl/aoc_day3_pkg.sv
// aoc_day3_pkg: shared types and helpers for the joltage-bank solver.
// Imported by the digit stack and the top-level line/sum engine.
package aoc_day3_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    CONVERT,
    EMIT,
    DRAIN
  } state_e;

  typedef logic [3:0] digit_t;

  localparam int MAX_DIGIT = 9;

  // ceil(k * log2(10)), log2(10) ~= 3.32193; exact for any sane k
  function automatic int min_val_w(input int k);
    return (k * 332193 + 99999) / 100000;
  endfunction

  function automatic bit val_w_ok(input int k, input int w);
    return w >= min_val_w(k);
  endfunction

endpackage

// File: rtl/aoc_day3_bank_max_stack.sv
// digit_stack_k: K-entry monotonic stack, one pop-run plus push per cycle.
// Pops are floored at lo so the remaining digits can still fill K slots.
module digit_stack_k
  import aoc_day3_pkg::*;
#(
  parameter int K   = 12,
  parameter int RW  = 7,
  parameter int SPW = $clog2(K + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           push_en,
  input  digit_t         digit,
  input  logic [RW-1:0]  rem,
  output logic [SPW-1:0] sp,
  output logic [K*4-1:0] stack
);

  digit_t         stack_q [K];
  digit_t         stack_d [K];
  logic [SPW-1:0] sp_q, sp_d;
  logic [SPW-1:0] p;
  logic [RW-1:0]  lo;

  always_comb begin
    lo = (rem >= RW'(K)) ? '0 : RW'(K) - rem;
    p  = sp_q;
    for (int j = K - 1; j >= 0; j--) begin
      if (RW'(j) >= lo && SPW'(j) < sp_q && stack_q[j] < digit)
        p = SPW'(j);
    end
  end

  always_comb begin
    stack_d = stack_q;
    sp_d    = sp_q;
    if (clear) begin
      sp_d = '0;
    end else if (push_en) begin
      for (int j = 0; j < K; j++) begin
        if (SPW'(j) == p) stack_d[j] = digit;
      end
      sp_d = (p < SPW'(K)) ? p + 1'b1 : p;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
      for (int j = 0; j < K; j++) stack_q[j] <= '0;
    end else begin
      sp_q    <= sp_d;
      stack_q <= stack_d;
    end
  end

  always_comb begin
    stack = '0;
    for (int j = 0; j < K; j++) stack[j*4 +: 4] = stack_q[j];
  end

  assign sp = sp_q;

endmodule

// File: rtl/aoc_day3_bank_max.sv
// aoc_day3_bank_max: per-line largest K-digit subsequence, converted to
// binary and accumulated into a running sum.
module aoc_day3_bank_max
  import aoc_day3_pkg::*;
#(
  parameter int NUM_DIGITS = 12,
  parameter int LINE_LEN   = 100,
  parameter int VAL_W      = 41,
  parameter int SUM_W      = 56
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_last,
  output logic             line_valid,
  output logic [VAL_W-1:0] line_value,
  output logic [SUM_W-1:0] sum_out,
  output logic             error
);

  localparam int K   = NUM_DIGITS;
  localparam int RW  = $clog2(LINE_LEN + 1);
  localparam int SPW = $clog2(K + 1);
  localparam int CW  = (K > 1) ? $clog2(K) : 1;

  if (K < 1 || K > LINE_LEN || !val_w_ok(K, VAL_W)) begin : g_bad_cfg
    $error("aoc_day3_bank_max: illegal NUM_DIGITS/LINE_LEN/VAL_W");
  end

  state_e           state_q, state_d;
  logic [RW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             err_q, err_d;

  logic             accept, at_end, bad, clr, push, full;
  logic [RW-1:0]    rem;
  logic [SPW-1:0]   sp_w;
  logic [K*4-1:0]   stack_w;
  digit_t           cur;

  assign in_ready = (state_q == COLLECT) || (state_q == DRAIN);
  assign accept   = in_valid && in_ready;
  assign at_end   = (idx_q == RW'(LINE_LEN - 1));
  assign bad      = (in_digit > digit_t'(MAX_DIGIT)) || (in_last != at_end);
  assign rem      = RW'(LINE_LEN) - idx_q;
  assign cur      = stack_w[{cnt_q, 2'b00} +: 4];
  assign full     = (sp_w == SPW'(K));

  digit_stack_k #(
    .K  (K),
    .RW (RW),
    .SPW(SPW)
  ) u_stack (
    .clk    (clk),
    .rst    (rst),
    .clear  (clr),
    .push_en(push),
    .digit  (in_digit),
    .rem    (rem),
    .sp     (sp_w),
    .stack  (stack_w)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    val_d   = val_q;
    sum_d   = sum_q;
    err_d   = err_q;
    clr     = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          if (bad) begin
            err_d = 1'b1;
            clr   = 1'b1;
            idx_d = '0;
            if (!in_last) state_d = DRAIN;
          end else begin
            push  = 1'b1;
            idx_d = idx_q + 1'b1;
            if (in_last) begin
              state_d = CONVERT;
              cnt_d   = '0;
              acc_d   = '0;
            end
          end
        end
      end
      CONVERT: begin
        acc_d = {acc_q[VAL_W-4:0], 3'b000}
              + {acc_q[VAL_W-2:0], 1'b0}
              + VAL_W'(cur);
        cnt_d = cnt_q + 1'b1;
        // result and sum land together so both are visible in EMIT
        if (cnt_q == CW'(K - 1)) begin
          state_d = EMIT;
          val_d   = acc_d;
          sum_d   = sum_q + SUM_W'(acc_d);
        end
      end
      EMIT: begin
        state_d = COLLECT;
        idx_d   = '0;
        clr     = 1'b1;
      end
      DRAIN: begin
        if (accept && in_last) begin
          state_d = COLLECT;
          idx_d   = '0;
          clr     = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      val_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      val_q   <= val_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  assign line_valid = (state_q == EMIT) && full;
  assign line_value = val_q;
  assign sum_out    = sum_q;
  assign error      = err_q;

endmodule

// File: tb/tb_aoc_day3_bank_max.sv
// tb_aoc_day3_bank_max: three configurations (K=2/15, K=12/15, K=3/14)
// driven through one shared bus, checked against a greedy reference.
module tb_aoc_day3_bank_max;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic        lst = 1'b0;
  logic [3:0]  dig = '0;
  int          sel = 0;

  logic        rdy_a  [3];
  logic        lv_a   [3];
  logic [40:0] lval_a [3];
  logic [55:0] sum_a  [3];
  logic        err_a  [3];

  logic        rdy, lv, err;
  logic [40:0] lval;
  logic [55:0] sum;

  assign rdy  = rdy_a[sel];
  assign lv   = lv_a[sel];
  assign lval = lval_a[sel];
  assign sum  = sum_a[sel];
  assign err  = err_a[sel];

  int kk [3] = '{2, 12, 3};
  int ll [3] = '{15, 15, 14};

  typedef struct {
    int     inst;
    longint line;
    int     len;
    int     gaps;
    longint val;
    longint sum;
  } vec_t;

  vec_t   tbl [9];
  int     cur [0:127];
  int     n;
  longint exp_sum [3];
  int     total = 0;
  int     bad   = 0;
  int     acc_cnt = 0;
  int     lv_cnt  = 0;

  always #5 clk = ~clk;

  aoc_day3_bank_max #(
    .NUM_DIGITS(2), .LINE_LEN(15), .VAL_W(41), .SUM_W(56)
  ) u_k2 (
    .clk(clk), .rst(rst), .in_valid(vld && sel == 0),
    .in_ready(rdy_a[0]), .in_digit(dig), .in_last(lst),
    .line_valid(lv_a[0]), .line_value(lval_a[0]),
    .sum_out(sum_a[0]), .error(err_a[0])
  );

  aoc_day3_bank_max #(
    .NUM_DIGITS(12), .LINE_LEN(15), .VAL_W(41), .SUM_W(56)
  ) u_k12 (
    .clk(clk), .rst(rst), .in_valid(vld && sel == 1),
    .in_ready(rdy_a[1]), .in_digit(dig), .in_last(lst),
    .line_valid(lv_a[1]), .line_value(lval_a[1]),
    .sum_out(sum_a[1]), .error(err_a[1])
  );

  aoc_day3_bank_max #(
    .NUM_DIGITS(3), .LINE_LEN(14), .VAL_W(41), .SUM_W(56)
  ) u_k3 (
    .clk(clk), .rst(rst), .in_valid(vld && sel == 2),
    .in_ready(rdy_a[2]), .in_digit(dig), .in_last(lst),
    .line_valid(lv_a[2]), .line_value(lval_a[2]),
    .sum_out(sum_a[2]), .error(err_a[2])
  );

  always @(posedge clk) if (!rst && vld && rdy) acc_cnt++;
  always @(negedge clk) if (lv) lv_cnt++;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Greedy reference: leftmost max digit in each shrinking window.
  function automatic longint best_k(input int k);
    longint v = 0;
    int     start = 0;
    for (int i = 0; i < k; i++) begin
      int bd = -1;
      int bp = start;
      for (int j = start; j <= n - k + i; j++) begin
        if (cur[j] > bd) begin
          bd = cur[j];
          bp = j;
        end
      end
      v = v * 10 + longint'(bd);
      start = bp + 1;
    end
    return v;
  endfunction

  task automatic load(input longint num, input int len);
    n = len;
    for (int i = len - 1; i >= 0; i--) begin
      cur[i] = int'(num % 10);
      num = num / 10;
    end
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_sum[i] = 0;
  endtask

  task automatic beat(input int d, input logic last);
    int t = 0;
    vld = 1'b1;
    dig = 4'(d);
    lst = last;
    while (!rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rdy) check("ready_timeout", 64'(rdy), 1);
    @(negedge clk);
    vld = 1'b0;
    lst = 1'b0;
  endtask

  task automatic send_line(input int gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps > 0) repeat ($urandom_range(0, gaps)) @(negedge clk);
      beat(cur[i], i == n - 1);
    end
  endtask

  task automatic wait_result(output int lat, output int lowc,
                             output logic [63:0] v, output logic got);
    got = 1'b0;
    lat = 0;
    lowc = 0;
    v = '0;
    for (int c = 1; c <= 60; c++) begin
      if (lv && !got) begin
        got = 1'b1;
        lat = c;
        v = 64'(lval);
      end
      if (rdy) begin
        lowc = c - 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_line(input int inst, input int gaps, input longint ev,
                          input longint es, input string tag);
    int          lat, lowc, base;
    logic        got;
    logic [63:0] v;
    sel = inst;
    #1;
    base = acc_cnt;
    send_line(gaps);
    wait_result(lat, lowc, v, got);
    check({tag, "_valid"}, 64'(got), 1);
    check({tag, "_value"}, v, ev);
    check({tag, "_latency"}, lat, kk[inst] + 1);
    check({tag, "_rdylow"}, lowc, kk[inst] + 1);
    check({tag, "_count"}, acc_cnt - base, n);
    check({tag, "_sum"}, 64'(sum), es);
  endtask

  initial begin
    int base;
    tbl[0] = '{0, 64'd987654321111111, 15, 0, 64'd98, 64'd98};
    tbl[1] = '{0, 64'd811111111111119, 15, 0, 64'd89, 64'd187};
    tbl[2] = '{0, 64'd234234234234278, 15, 0, 64'd78, 64'd265};
    tbl[3] = '{0, 64'd818181911112111, 15, 0, 64'd92, 64'd357};
    tbl[4] = '{1, 64'd987654321111111, 15, 0,
               64'd987654321111, 64'd987654321111};
    tbl[5] = '{1, 64'd811111111111119, 15, 0,
               64'd811111111119, 64'd1798765432230};
    tbl[6] = '{1, 64'd234234234234278, 15, 0,
               64'd434234234278, 64'd2232999666508};
    tbl[7] = '{1, 64'd818181911112111, 15, 0,
               64'd888911112111, 64'd3121910778619};
    tbl[8] = '{2, 64'd36478936584634, 14, 3, 64'd986, 64'd986};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check("rst_ready", 64'(rdy), 1);
      check("rst_valid", 64'(lv), 0);
      check("rst_value", 64'(lval), 0);
      check("rst_sum", 64'(sum), 0);
      check("rst_error", 64'(err), 0);
    end
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      load(tbl[i].line, tbl[i].len);
      run_line(tbl[i].inst, tbl[i].gaps, tbl[i].val, tbl[i].sum,
               $sformatf("vec%0d", i));
    end

    // bad digit on the third beat
    do_rst();
    sel = 0;
    #1;
    load(64'd987654321111111, 15);
    cur[2] = 10;
    base = lv_cnt;
    send_line(0);
    repeat (5) @(negedge clk);
    check("baddig_error", 64'(err), 1);
    check("baddig_nopulse", lv_cnt - base, 0);
    check("baddig_sum", 64'(sum), 0);
    load(64'd987654321111111, 15);
    run_line(0, 0, 98, 98, "after_baddig");
    check("baddig_sticky", 64'(err), 1);

    // in_last on the tenth beat
    do_rst();
    sel = 0;
    #1;
    load(64'd9876543211, 10);
    base = lv_cnt;
    send_line(0);
    repeat (5) @(negedge clk);
    check("early_error", 64'(err), 1);
    check("early_nopulse", lv_cnt - base, 0);
    check("early_sum", 64'(sum), 0);
    load(64'd811111111111119, 15);
    run_line(0, 0, 89, 89, "after_early");

    // reset in the middle of CONVERT
    do_rst();
    sel = 1;
    #1;
    load(64'd987654321111111, 15);
    base = lv_cnt;
    send_line(0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 64'(rdy), 1);
    check("midrst_sum", 64'(sum), 0);
    check("midrst_error", 64'(err), 0);
    repeat (20) @(negedge clk);
    check("midrst_nopulse", lv_cnt - base, 0);
    check("midrst_sum_late", 64'(sum), 0);

    // random lines against the greedy model
    do_rst();
    for (int r = 0; r < 30; r++) begin
      int     inst;
      longint ev;
      inst = r % 3;
      n = ll[inst];
      for (int i = 0; i < n; i++) cur[i] = int'($urandom_range(0, 9));
      ev = best_k(kk[inst]);
      exp_sum[inst] = exp_sum[inst] + ev;
      run_line(inst, r % 4, ev, exp_sum[inst], $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
